// File: rtl/usb_stat_match_multi_if.sv
// Bus between the USB register block and the multi-channel STAT monitor.
// All signals live in the fe_clk domain.
//   master : register block side (drives config/arm/select, reads results)
//   slave  : monitor side
// Inputs : I_arm, I_stat, I_pattern, I_mask, I_edge_mode, I_min_cycles,
//          I_clear, I_rd_sel
// Outputs: O_rd_captured, O_rd_stat, O_rd_time, O_rd_count, O_captured,
//          O_any_match
interface usb_stat_match_multi_if #(
  parameter int pNUM_CH       = 4,
  parameter int pSTAT_WIDTH   = 5,
  parameter int pTIME_WIDTH   = 24,
  parameter int pCOUNT_WIDTH  = 16,
  parameter int pMINLEN_WIDTH = 8,
  parameter int pSEL_WIDTH    = 4
);
  logic                             I_arm;
  logic [pSTAT_WIDTH-1:0]           I_stat;
  logic [pNUM_CH*pSTAT_WIDTH-1:0]   I_pattern;
  logic [pNUM_CH*pSTAT_WIDTH-1:0]   I_mask;
  logic [pNUM_CH-1:0]               I_edge_mode;
  logic [pMINLEN_WIDTH-1:0]         I_min_cycles;
  logic [pNUM_CH-1:0]               I_clear;
  logic [pSEL_WIDTH-1:0]            I_rd_sel;
  logic                             O_rd_captured;
  logic [pSTAT_WIDTH-1:0]           O_rd_stat;
  logic [pTIME_WIDTH-1:0]           O_rd_time;
  logic [pCOUNT_WIDTH-1:0]          O_rd_count;
  logic [pNUM_CH-1:0]               O_captured;
  logic                             O_any_match;

  modport master (
    output I_arm, I_stat, I_pattern, I_mask, I_edge_mode, I_min_cycles,
           I_clear, I_rd_sel,
    input  O_rd_captured, O_rd_stat, O_rd_time, O_rd_count, O_captured,
           O_any_match
  );

  modport slave (
    input  I_arm, I_stat, I_pattern, I_mask, I_edge_mode, I_min_cycles,
           I_clear, I_rd_sel,
    output O_rd_captured, O_rd_stat, O_rd_time, O_rd_count, O_captured,
           O_any_match
  );
endinterface

// File: rtl/usb_stat_match_multi.sv
// Multi-channel front-end STAT pattern monitor (fe_clk domain).
// Each channel compares the capture-status bus against its own
// pattern/mask, qualifies matches by a minimum run length, counts events
// (level or edge) and captures the first qualified value with an
// arm-relative timestamp. Results are read through a registered
// channel-select port.
// Ports: fe_clk, reset_n (async, active low), bus (slave modport).

// Per-channel matcher, counter and capture registers.
module usb_stat_match_ch #(
  parameter int STAT_W   = 5,
  parameter int TIME_W   = 24,
  parameter int COUNT_W  = 16,
  parameter int MINLEN_W = 8
) (
  input  logic                fe_clk,
  input  logic                reset_n,
  input  logic                arm,
  input  logic                arm_rise,
  input  logic [TIME_W-1:0]   timestamp,
  input  logic [STAT_W-1:0]   stat,
  input  logic [STAT_W-1:0]   pattern,
  input  logic [STAT_W-1:0]   mask,
  input  logic                edge_mode,
  input  logic [MINLEN_W-1:0] min_cycles,
  input  logic                clear,
  output logic                q,
  output logic                captured,
  output logic [STAT_W-1:0]   stat_cap,
  output logic [TIME_W-1:0]   time_cap,
  output logic [COUNT_W-1:0]  count
);
  logic                m;
  logic [MINLEN_W-1:0] run;
  logic [MINLEN_W:0]   run_inc;
  logic                q_r;
  logic                evt;
  logic                clr;

  assign m       = ((stat ^ pattern) & mask) == '0;
  // Extra bit keeps run+1 from wrapping when run is saturated.
  assign run_inc = {1'b0, run} + (MINLEN_W+1)'(1);
  assign q       = m & (run_inc >= {1'b0, min_cycles});
  assign evt     = edge_mode ? (q & ~q_r) : q;
  assign clr     = arm_rise | clear;

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      run      <= '0;
      q_r      <= 1'b0;
      captured <= 1'b0;
      stat_cap <= '0;
      time_cap <= '0;
      count    <= '0;
    end else if (clr) begin
      run      <= '0;
      q_r      <= 1'b0;
      captured <= 1'b0;
      stat_cap <= '0;
      time_cap <= '0;
      count    <= '0;
    end else begin
      if (!m)            run <= '0;
      else if (run != '1) run <= run + MINLEN_W'(1);
      q_r <= q;
      if (arm && evt && count != '1)
        count <= count + COUNT_W'(1);
      if (!captured && q && arm) begin
        captured <= 1'b1;
        stat_cap <= stat;
        time_cap <= timestamp;
      end
    end
  end
endmodule

module usb_stat_match_multi #(
  parameter int pNUM_CH       = 4,
  parameter int pSTAT_WIDTH   = 5,
  parameter int pTIME_WIDTH   = 24,
  parameter int pCOUNT_WIDTH  = 16,
  parameter int pMINLEN_WIDTH = 8,
  parameter int pSEL_WIDTH    = 4
) (
  input  logic                  fe_clk,
  input  logic                  reset_n,
  usb_stat_match_multi_if.slave bus
);
  logic                                      arm_r;
  logic                                      arm_rise;
  logic [pTIME_WIDTH-1:0]                    timestamp;
  logic [pNUM_CH-1:0]                        q;
  logic [pNUM_CH-1:0]                        captured;
  logic [pNUM_CH-1:0][pSTAT_WIDTH-1:0]       stat_cap;
  logic [pNUM_CH-1:0][pTIME_WIDTH-1:0]       time_cap;
  logic [pNUM_CH-1:0][pCOUNT_WIDTH-1:0]      count;

  logic                                      sel_cap;
  logic [pSTAT_WIDTH-1:0]                    sel_stat;
  logic [pTIME_WIDTH-1:0]                    sel_time;
  logic [pCOUNT_WIDTH-1:0]                   sel_count;

  logic                                      rd_captured;
  logic [pSTAT_WIDTH-1:0]                    rd_stat;
  logic [pTIME_WIDTH-1:0]                    rd_time;
  logic [pCOUNT_WIDTH-1:0]                   rd_count;
  logic                                      any_match;

  assign arm_rise = bus.I_arm & ~arm_r;

  // Timestamp restarts on arm, runs while armed, holds while disarmed.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_r     <= 1'b0;
      timestamp <= '0;
    end else begin
      arm_r <= bus.I_arm;
      if (arm_rise)
        timestamp <= '0;
      else if (bus.I_arm && timestamp != '1)
        timestamp <= timestamp + pTIME_WIDTH'(1);
    end
  end

  for (genvar n = 0; n < pNUM_CH; n++) begin : g_ch
    usb_stat_match_ch #(
      .STAT_W   (pSTAT_WIDTH),
      .TIME_W   (pTIME_WIDTH),
      .COUNT_W  (pCOUNT_WIDTH),
      .MINLEN_W (pMINLEN_WIDTH)
    ) u_ch (
      .fe_clk     (fe_clk),
      .reset_n    (reset_n),
      .arm        (bus.I_arm),
      .arm_rise   (arm_rise),
      .timestamp  (timestamp),
      .stat       (bus.I_stat),
      .pattern    (bus.I_pattern[n*pSTAT_WIDTH +: pSTAT_WIDTH]),
      .mask       (bus.I_mask[n*pSTAT_WIDTH +: pSTAT_WIDTH]),
      .edge_mode  (bus.I_edge_mode[n]),
      .min_cycles (bus.I_min_cycles),
      .clear      (bus.I_clear[n]),
      .q          (q[n]),
      .captured   (captured[n]),
      .stat_cap   (stat_cap[n]),
      .time_cap   (time_cap[n]),
      .count      (count[n])
    );
  end

  // Select mux; an out-of-range select matches no channel and reads 0.
  always_comb begin
    sel_cap   = 1'b0;
    sel_stat  = '0;
    sel_time  = '0;
    sel_count = '0;
    for (int n = 0; n < pNUM_CH; n++) begin
      if (bus.I_rd_sel == pSEL_WIDTH'(n)) begin
        sel_cap   = captured[n];
        sel_stat  = stat_cap[n];
        sel_time  = time_cap[n];
        sel_count = count[n];
      end
    end
  end

  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_captured <= 1'b0;
      rd_stat     <= '0;
      rd_time     <= '0;
      rd_count    <= '0;
      any_match   <= 1'b0;
    end else begin
      rd_captured <= sel_cap;
      rd_stat     <= sel_stat;
      rd_time     <= sel_time;
      rd_count    <= sel_count;
      any_match   <= |q;
    end
  end

  assign bus.O_rd_captured = rd_captured;
  assign bus.O_rd_stat     = rd_stat;
  assign bus.O_rd_time     = rd_time;
  assign bus.O_rd_count    = rd_count;
  assign bus.O_captured    = captured;
  assign bus.O_any_match   = any_match;
endmodule

// File: tb/tb_usb_stat_match_multi.sv
module tb_usb_stat_match_multi;
  localparam int NCH = 4;
  localparam int SW  = 5;
  localparam int TW  = 24;
  localparam int CW  = 4;
  localparam int MW  = 8;
  localparam int LW  = 4;

  logic fe_clk = 1'b0;
  logic reset_n;
  always #5 fe_clk = ~fe_clk;

  usb_stat_match_multi_if #(
    .pNUM_CH(NCH), .pSTAT_WIDTH(SW), .pTIME_WIDTH(TW),
    .pCOUNT_WIDTH(CW), .pMINLEN_WIDTH(MW), .pSEL_WIDTH(LW)
  ) bus ();

  usb_stat_match_multi #(
    .pNUM_CH(NCH), .pSTAT_WIDTH(SW), .pTIME_WIDTH(TW),
    .pCOUNT_WIDTH(CW), .pMINLEN_WIDTH(MW), .pSEL_WIDTH(LW)
  ) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic          cap;
    logic [SW-1:0] st;
    logic [TW-1:0] tm;
    logic [CW-1:0] cnt;
  } rd_exp_t;

  rd_exp_t sb[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Readout request: expected values are the channel state visible now,
  // which the registered port presents after the next edge.
  task automatic rd(input int sel, input logic cap, input logic [SW-1:0] st,
                    input logic [TW-1:0] tm, input logic [CW-1:0] cnt);
    rd_exp_t e;
    bus.I_rd_sel = LW'(sel);
    e.cap = cap; e.st = st; e.tm = tm; e.cnt = cnt;
    sb.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    rd_exp_t e;
    repeat (n) begin
      @(posedge fe_clk); #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rd_cap",   32'(bus.O_rd_captured), 32'(e.cap));
        chk("rd_stat",  32'(bus.O_rd_stat),     32'(e.st));
        chk("rd_time",  32'(bus.O_rd_time),     32'(e.tm));
        chk("rd_count", 32'(bus.O_rd_count),    32'(e.cnt));
      end
    end
  endtask

  task automatic set_ch(input int n, input logic [SW-1:0] pat,
                        input logic [SW-1:0] msk, input logic edg);
    bus.I_pattern[n*SW +: SW] = pat;
    bus.I_mask[n*SW +: SW]    = msk;
    bus.I_edge_mode[n]        = edg;
  endtask

  initial begin
    reset_n          = 1'b0;
    bus.I_arm        = 1'b0;
    bus.I_stat       = '0;
    bus.I_pattern    = '0;
    bus.I_mask       = '0;
    bus.I_edge_mode  = '0;
    bus.I_min_cycles = '0;
    bus.I_clear      = '0;
    bus.I_rd_sel     = '0;
    set_ch(0, 5'h12, 5'h1F, 1'b0);
    set_ch(1, 5'h1F, 5'h1F, 1'b0);
    set_ch(2, 5'h1F, 5'h1F, 1'b0);
    set_ch(3, 5'h07, 5'h1F, 1'b0);
    tick(2);

    // Reset asserted while ch2 is counting
    reset_n = 1'b1;
    set_ch(2, 5'h00, 5'h00, 1'b0);
    bus.I_rd_sel = 2;
    bus.I_arm = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    chk("rst_captured", 32'(bus.O_captured),    0);
    chk("rst_rd_cap",   32'(bus.O_rd_captured), 0);
    chk("rst_rd_count", 32'(bus.O_rd_count),    0);
    chk("rst_any",      32'(bus.O_any_match),   0);
    bus.I_arm = 1'b0;
    tick(2);
    reset_n = 1'b1;
    set_ch(1, 5'h00, 5'h00, 1'b1);
    tick(1);
    rd(2, 0, 0, 0, 0);
    tick(1);

    // Session 1: min_cycles = 0, arm edge at P0, timestamp after Pk = k
    bus.I_arm = 1'b1;
    tick(1);
    chk("any_after_arm", 32'(bus.O_any_match), 1);
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (k == 5) rd(2, 1, 0, 0, 5);  // level count = armed cycles
    end
    bus.I_stat = 5'h12;                // sampled at P11..P13, ts=10 at P11
    tick(3);
    bus.I_stat = 5'h13;
    set_ch(0, 5'h12, 5'h1E, 1'b0);     // still matches, must not recapture
    tick(1);
    chk("captured_s1", 32'(bus.O_captured), 32'h7);
    bus.I_stat = 5'h00;
    rd(0, 1, 5'h12, 10, 4);
    tick(1);
    rd(1, 1, 0, 0, 1);                 // edge mode: one entry only
    tick(1);
    rd(2, 1, 0, 0, 15);                // saturated at 15
    tick(1);
    rd(NCH, 0, 0, 0, 0);               // out-of-range select
    tick(1);

    // Clear priority over a qualifying match (at P19)
    set_ch(0, 5'h12, 5'h1F, 1'b0);
    bus.I_stat  = 5'h12;
    bus.I_clear = 4'b0001;
    tick(1);
    bus.I_clear = '0;
    bus.I_stat  = 5'h00;
    chk("captured_clr", 32'(bus.O_captured), 32'h6);
    rd(1, 1, 0, 0, 1);
    tick(1);
    rd(0, 0, 0, 0, 0);
    tick(1);
    bus.I_stat = 5'h12;                // recapture at P22, ts before = 21
    tick(1);
    bus.I_stat = 5'h00;
    chk("captured_recap", 32'(bus.O_captured), 32'h7);
    rd(0, 1, 5'h12, 21, 1);
    tick(1);

    // Disarm: no counting, no capture; any_match ignores arm
    bus.I_arm   = 1'b0;
    bus.I_clear = 4'b0001;
    tick(1);
    bus.I_clear = '0;
    bus.I_stat  = 5'h12;
    tick(2);
    bus.I_stat = 5'h00;
    chk("any_disarmed", 32'(bus.O_any_match), 1);
    rd(0, 0, 0, 0, 0);
    tick(1);

    // Session 2: min_cycles = 4, runs of 3 then 5 cycles, edge mode
    bus.I_min_cycles = 8'd4;
    set_ch(0, 5'h12, 5'h1F, 1'b1);
    set_ch(1, 5'h1F, 5'h1F, 1'b1);
    set_ch(2, 5'h1F, 5'h1F, 1'b0);
    tick(2);
    bus.I_arm = 1'b1;
    tick(1);                           // Q0
    tick(2);                           // Q1, Q2
    bus.I_stat = 5'h12;
    tick(3);                           // Q3..Q5 : short run
    bus.I_stat = 5'h00;
    tick(1);                           // Q6
    bus.I_stat = 5'h12;
    tick(3);                           // Q7..Q9
    chk("min_nocap",  32'(bus.O_captured[0]), 0);
    chk("min_noany",  32'(bus.O_any_match),   0);
    tick(1);                           // Q10 : 4th cycle of run
    chk("min_cap",    32'(bus.O_captured[0]), 1);
    chk("min_any",    32'(bus.O_any_match),   1);
    tick(1);                           // Q11
    bus.I_stat = 5'h00;
    tick(1);                           // Q12
    chk("min_any_off", 32'(bus.O_any_match), 0);
    rd(0, 1, 5'h12, 9, 1);
    tick(2);

    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/usb_stat_match_multi.md
Name: usb_stat_match_multi

Overview:
- Multi-channel successor to the single-channel front-end STAT pattern monitor.
- Runs entirely in the fe_clk domain and watches the front-end capture-status bus against pNUM_CH independent pattern/mask pairs.
- Per channel it captures the first qualified match value and its arm-relative timestamp, and counts match events in level or edge mode, with a minimum-duration qualifier.
- Results go through a registered channel-select readout port, which the USB register block samples via its CDC stage.

Parameters:
- pNUM_CH, 4, number of match channels (1..16).
- pSTAT_WIDTH, 5, width of the monitored status bus.
- pTIME_WIDTH, 24, width of the arm-relative timestamp counter.
- pCOUNT_WIDTH, 16, width of each per-channel event counter.
- pMINLEN_WIDTH, 8, width of the minimum-duration qualifier and run counters.
- pSEL_WIDTH, 4, width of the readout channel select.

Ports:
- fe_clk  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- I_arm  in  1  arm level, already synchronised to fe_clk; its rising edge clears all channels and the timestamp.
- I_stat  in  pSTAT_WIDTH  front-end capture status.
- I_pattern  in  pNUM_CH*pSTAT_WIDTH  per-channel pattern; channel n is at [n*pSTAT_WIDTH +: pSTAT_WIDTH].
- I_mask  in  pNUM_CH*pSTAT_WIDTH  per-channel mask; 1 = bit compared.
- I_edge_mode  in  pNUM_CH  per channel: 1 = count entries into the qualified match, 0 = count qualified cycles.
- I_min_cycles  in  pMINLEN_WIDTH  consecutive raw-match cycles required to qualify; 0 and 1 both mean immediate.
- I_clear  in  pNUM_CH  per-channel single-cycle clear pulse.
- I_rd_sel  in  pSEL_WIDTH  readout channel select.
- O_rd_captured  out  1  captured flag of the selected channel.
- O_rd_stat  out  pSTAT_WIDTH  captured status value.
- O_rd_time  out  pTIME_WIDTH  captured timestamp.
- O_rd_count  out  pCOUNT_WIDTH  event count.
- O_captured  out  pNUM_CH  captured flags of all channels.
- O_any_match  out  1  registered OR of all channels' qualified match.

Behaviour:
- Reset: asynchronous on reset_n low. Every register and output goes to 0: arm_r, timestamp, and all per-channel run, q_r, captured, stat_cap, time_cap, count.
- Arm edge: arm_r <= I_arm; arm_rise = I_arm & ~arm_r.
- Timestamp:
  - arm_rise: set to 0.
  - I_arm high otherwise: increment by 1, saturating at all-ones (no wrap).
  - I_arm low: hold.
- Raw match, channel n: m = ((I_stat ^ pattern_n) & mask_n) == 0. An all-zero mask always matches.
- Run counter: m ? saturating run+1 : 0.
- Qualified match: q = m & ((run+1) >= I_min_cycles), computed combinationally in the same cycle from the pre-increment run, evaluated with one extra bit so saturation cannot wrap. I_min_cycles of 0 or 1 gives q = m.
- Event: edge mode gives q & ~q_r; level mode gives q. q_r <= q every cycle.
- Count:
  - Increments on an event only while I_arm is high.
  - Saturates at all-ones.
- Capture:
  - Fires when ~captured & q & I_arm & ~arm_rise.
  - Sets captured <= 1, stat_cap <= I_stat, time_cap <= the current timestamp register value.
  - Once captured is set, later matches do not overwrite stat_cap or time_cap.
- Clear, channel n (clr = arm_rise | I_clear[n]):
  - Zeroes captured, stat_cap, time_cap, count, run and q_r for that channel.
  - Takes priority over capture and count in the same cycle.
  - An I_clear on one channel leaves the other channels untouched.
- Disarm: I_arm falling freezes counts and blocks new captures. Captured data is held until the next arm_rise or clear.
- Configuration change: I_pattern, I_mask, I_edge_mode and I_min_cycles are sampled live, with no internal shadowing. The register block pulses I_clear after updating a channel.
- Readout:
  - Registered, latency 1 cycle: O_rd_* <= the fields of channel I_rd_sel.
  - I_rd_sel >= pNUM_CH drives all O_rd_* to 0.
  - The readout reflects post-update state one cycle after an event.
- O_captured is a direct view of the captured flags.
- O_any_match <= |q over all channels, registered, independent of I_arm.

Test Plan:
- Reset and arm: assert reset_n=0 mid-count, then release and raise I_arm -> all outputs 0; timestamp 0 in the cycle after the arm edge, then +1 per cycle.
- First-match capture: ch0 pattern=5'h12 mask=5'h1F; drive I_stat=5'h12 for 3 cycles starting 10 cycles after the arm edge -> O_captured[0]=1, rd_stat=5'h12, rd_time=10; rd_stat and rd_time unchanged by a later match with 5'h13 under mask 5'h1E.
- Edge vs level count: ch1 edge=1, ch2 edge=0, both mask=0; I_stat pulses are irrelevant, with I_min_cycles=0 -> ch1 count=1, ch2 count equals the number of armed cycles.
- Minimum duration: I_min_cycles=4, matches of 3 then 5 cycles -> a single qualifying event; capture occurs on the 4th cycle of the second run.
- Clear priority: pulse I_clear[0] in the same cycle as a qualifying match -> ch0 captured=0 and count=0 afterwards; ch1 unaffected; ch0 recaptures on its next match.
- Saturation and bad select: pCOUNT_WIDTH=4 in level mode for 20 armed cycles -> count=15; I_rd_sel=pNUM_CH -> O_rd_* all 0 one cycle later.
